// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: deserializes an SOF-headed pixel frame, streams pixels
// into the frame buffer and reports exactly one done/err pulse per cs_n-low transaction.
module spi_frame_rx #(
   parameter int         CDEPTH = 4,
   parameter int         NPIX   = 1024,
   parameter logic [7:0] SOF    = 8'hA5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sck,
   input  logic                sdi,
   input  logic                cs_n,
   output logic                wen,
   output logic [9:0]          waddr,
   output logic [3*CDEPTH-1:0] wpix,
   output logic                done,
   output logic                err,
   output logic                busy,
   output logic [2:0]          dbg_state_o
);

   localparam int         PW        = 3 * CDEPTH;
   localparam logic [9:0] LAST_ADDR = 10'(NPIX - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_PIX   = 3'd2,
      S_CSUM  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   logic       sck_s1_q, sck_s2_q, sck_prev_q;
   logic       sdi_s1_q, sdi_s2_q;
   logic       cs_s1_q, cs_s2_q, cs_prev_q;
   logic       cs_hi_q;
   logic [1:0] fill_q;

   logic [2:0] bit_cnt_q;
   logic [6:0] shift_q;

   state_t          state_q, state_d;
   logic            byte_sel_q, byte_sel_d;
   logic [7:0]      hi_byte_q, hi_byte_d;
   logic [7:0]      csum_q, csum_d;
   logic            wen_q, wen_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [9:0]      waddr_q, waddr_d;
   logic [PW-1:0]   wpix_q, wpix_d;

   logic       sck_rise, cs_fall, cs_rise, byte_done;
   logic [7:0] rx_byte;

   // cs_hi_q only trusts the synchronized cs_n once the pipeline holds real pin
   // samples, so a cs_n already low at reset release is not mistaken for a new frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_prev_q <= 1'b0;
         sdi_s1_q   <= 1'b0;
         sdi_s2_q   <= 1'b0;
         cs_s1_q    <= 1'b1;
         cs_s2_q    <= 1'b1;
         cs_prev_q  <= 1'b1;
         cs_hi_q    <= 1'b0;
         fill_q     <= 2'b00;
      end else begin
         sck_s1_q   <= sck;
         sck_s2_q   <= sck_s1_q;
         sck_prev_q <= sck_s2_q;
         sdi_s1_q   <= sdi;
         sdi_s2_q   <= sdi_s1_q;
         cs_s1_q    <= cs_n;
         cs_s2_q    <= cs_s1_q;
         cs_prev_q  <= cs_s2_q;
         cs_hi_q    <= cs_s2_q & fill_q[1];
         fill_q     <= {fill_q[0], 1'b1};
      end
   end

   assign sck_rise  = sck_s2_q & ~sck_prev_q & ~cs_s2_q;
   assign cs_fall   = cs_hi_q & ~cs_s2_q;
   assign cs_rise   = cs_s2_q & ~cs_prev_q;
   assign byte_done = sck_rise & (bit_cnt_q == 3'd7);
   assign rx_byte   = {shift_q, sdi_s2_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt_q <= 3'd0;
         shift_q   <= 7'd0;
      end else if (cs_s2_q) begin
         bit_cnt_q <= 3'd0;
      end else if (sck_rise) begin
         shift_q   <= {shift_q[5:0], sdi_s2_q};
         bit_cnt_q <= bit_cnt_q + 3'd1;
      end
   end

   // Write port: wen is a one-cycle strobe and waddr/wpix are meaningful only in
   // that cycle; the frame buffer always accepts, so there is no ready/back-pressure.
   always_comb begin
      state_d    = state_q;
      byte_sel_d = byte_sel_q;
      hi_byte_d  = hi_byte_q;
      csum_d     = csum_q;
      wen_d      = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      waddr_d    = waddr_q;
      wpix_d     = wpix_q;

      if (wen_q && (waddr_q != LAST_ADDR)) begin
         waddr_d = waddr_q + 10'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               state_d    = S_HDR;
               byte_sel_d = 1'b0;
               csum_d     = 8'd0;
               waddr_d    = 10'd0;
            end
         end
         S_HDR: begin
            if (cs_rise) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (byte_done) begin
               if (rx_byte == SOF) begin
                  state_d = S_PIX;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_DRAIN;
               end
            end
         end
         S_PIX: begin
            if (cs_rise) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (byte_done) begin
               csum_d = csum_q ^ rx_byte;
               if (!byte_sel_q) begin
                  hi_byte_d  = rx_byte;
                  byte_sel_d = 1'b1;
               end else begin
                  byte_sel_d = 1'b0;
                  wen_d      = 1'b1;
                  wpix_d     = PW'({hi_byte_q, rx_byte});
                  if (waddr_q == LAST_ADDR) begin
                     state_d = S_CSUM;
                  end
               end
            end
         end
         S_CSUM: begin
            if (cs_rise) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (byte_done) begin
               if (rx_byte == csum_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cs_s2_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         byte_sel_q <= 1'b0;
         hi_byte_q  <= 8'd0;
         csum_q     <= 8'd0;
         wen_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         waddr_q    <= 10'd0;
         wpix_q     <= '0;
      end else begin
         state_q    <= state_d;
         byte_sel_q <= byte_sel_d;
         hi_byte_q  <= hi_byte_d;
         csum_q     <= csum_d;
         wen_q      <= wen_d;
         done_q     <= done_d;
         err_q      <= err_d;
         waddr_q    <= waddr_d;
         wpix_q     <= wpix_d;
      end
   end

   assign wen         = wen_q;
   assign waddr       = waddr_q;
   assign wpix        = wpix_q;
   assign done        = done_q;
   assign err         = err_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule
